// File: rtl/splitter.sv
// ---------------------------------------------------------------------------
// splitter
//   Splits a DATA_W-bit word into its upper and lower halves. Two views of
//   the same input word are provided:
//     * a zero-latency combinational split of `a` (low/high);
//     * a valid/ready-handshaked, registered copy of the halves, held in a
//       2-entry FIFO (low_q/high_q).
//   Bridges the 16-bit datapath buses and the 8-bit byte consumers.
//
// Parameters
//   DATA_W    input word width; must be even and >= 2 (default 16)
//   HALF_W    DATA_W/2, derived (localparam, not overridable)
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   a          in   DATA_W  word to split
//   low        out  HALF_W  combinational a[HALF_W-1:0]
//   high       out  HALF_W  combinational a[DATA_W-1:HALF_W]
//   in_valid   in   1       `a` offered to the registered path
//   in_ready   out  1       FIFO has room (count != 2)
//   out_valid  out  1       low_q/high_q hold valid data (count != 0)
//   out_ready  in   1       consumer accepts low_q/high_q
//   low_q      out  HALF_W  lower half of the oldest buffered word (0 if empty)
//   high_q     out  HALF_W  upper half of the oldest buffered word (0 if empty)
//
// Optional feature (macro SPLITTER_PARITY_EN)
//   par_low    out  1       XOR reduction of low_q  (0 if empty / in reset)
//   par_high   out  1       XOR reduction of high_q (0 if empty / in reset)
//   Parity is computed at push time and stored with the data in each entry.
// ---------------------------------------------------------------------------
module splitter #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   a,
  output logic [DATA_W/2-1:0] low,
  output logic [DATA_W/2-1:0] high,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W/2-1:0] low_q,
`ifdef SPLITTER_PARITY_EN
  output logic [DATA_W/2-1:0] high_q,
  output logic                par_low,
  output logic                par_high
`else
  output logic [DATA_W/2-1:0] high_q
`endif
);

  localparam int HALF_W = DATA_W / 2;

  // Combinational split: pure wiring, unaffected by clock, reset or handshake.
  assign low  = a[HALF_W-1:0];
  assign high = a[DATA_W-1:HALF_W];

  // FIFO state
  logic [HALF_W-1:0] mem_low  [2];
  logic [HALF_W-1:0] mem_high [2];
`ifdef SPLITTER_PARITY_EN
  logic              mem_par_low  [2];
  logic              mem_par_high [2];
`endif
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic push;
  logic pop;

  // Both flags come from registered count only, so in_ready never depends
  // combinationally on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the storage is cleared on reset as well, so nothing stale can
      // ever be presented and the empty/reset outputs are deterministic.
      for (int i = 0; i < 2; i++) begin
        mem_low[i]      <= '0;
        mem_high[i]     <= '0;
`ifdef SPLITTER_PARITY_EN
        mem_par_low[i]  <= 1'b0;
        mem_par_high[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        mem_low[wr_ptr]      <= a[HALF_W-1:0];
        mem_high[wr_ptr]     <= a[DATA_W-1:HALF_W];
`ifdef SPLITTER_PARITY_EN
        mem_par_low[wr_ptr]  <= ^a[HALF_W-1:0];
        mem_par_high[wr_ptr] <= ^a[DATA_W-1:HALF_W];
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output view of the head entry, forced to zero when the FIFO is empty.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    low_q  = '0;
    high_q = '0;
`ifdef SPLITTER_PARITY_EN
    par_low  = 1'b0;
    par_high = 1'b0;
`endif
    if (out_valid) begin
      low_q  = mem_low[rd_ptr];
      high_q = mem_high[rd_ptr];
`ifdef SPLITTER_PARITY_EN
      par_low  = mem_par_low[rd_ptr];
      par_high = mem_par_high[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_splitter.sv
// ---------------------------------------------------------------------------
// tb_splitter
//   Directed, self-checking bench for splitter (DATA_W = 16). Expected FIFO
//   contents are kept in a scoreboard queue filled when a push is driven and
//   drained when the consumer accepts a word; a bench-side occupancy model
//   predicts in_ready/out_valid. Parity checks are built in when
//   SPLITTER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  low, high, low_q, high_q;
  logic        in_valid, in_ready, out_valid, out_ready;
`ifdef SPLITTER_PARITY_EN
  logic        par_low, par_high;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       p_hi;
    logic       p_lo;
  } entry_t;

  entry_t sb[$];
  int     exp_count = 0;

  always #5 clk = ~clk;

  splitter #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .low       (low),
    .high      (high),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .low_q     (low_q),
`ifdef SPLITTER_PARITY_EN
    .high_q    (high_q),
    .par_low   (par_low),
    .par_high  (par_high)
`else
    .high_q    (high_q)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the registered outputs against the model, updates the model for
  // the upcoming edge, then advances to 1 ns after that edge.
  task automatic cycle();
    logic do_push, do_pop;
    check("in_ready",  {31'd0, in_ready},  {31'd0, exp_count != 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_count != 0});
    if (exp_count == 0) begin
      check("low_q_empty",  {24'd0, low_q},  32'd0);
      check("high_q_empty", {24'd0, high_q}, 32'd0);
`ifdef SPLITTER_PARITY_EN
      check("par_low_empty",  {31'd0, par_low},  32'd0);
      check("par_high_empty", {31'd0, par_high}, 32'd0);
`endif
    end else begin
      check("low_q",  {24'd0, low_q},  {24'd0, sb[0].lo});
      check("high_q", {24'd0, high_q}, {24'd0, sb[0].hi});
`ifdef SPLITTER_PARITY_EN
      check("par_low",  {31'd0, par_low},  {31'd0, sb[0].p_lo});
      check("par_high", {31'd0, par_high}, {31'd0, sb[0].p_hi});
`endif
    end
    do_push = in_valid && (exp_count != 2);
    do_pop  = out_ready && (exp_count != 0);
    if (do_push) sb.push_back('{hi: a[15:8], lo: a[7:0], p_hi: ^a[15:8], p_lo: ^a[7:0]});
    if (do_pop)  void'(sb.pop_front());
    exp_count = exp_count + int'(do_push) - int'(do_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic r);
    in_valid  = v;
    a         = w;
    out_ready = r;
    cycle();
  endtask

  logic [15:0] comb_vec [5];

  initial begin
    comb_vec = '{16'hFF00, 16'h00FF, 16'h8001, 16'hAA00, 16'h55AA};
    rst_n = 1'b0;
    a = 16'h0000;
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Combinational split, checked while still in reset.
    for (int i = 0; i < 5; i++) begin
      a = comb_vec[i];
      #1;
      check("comb_high", {24'd0, high}, {24'd0, comb_vec[i][15:8]});
      check("comb_low",  {24'd0, low},  {24'd0, comb_vec[i][7:0]});
      #99;
    end

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_low_q",     {24'd0, low_q},     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming: one word per cycle with out_ready held high.
    drive(1'b1, 16'h1234, 1'b1);
    drive(1'b1, 16'hABCD, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);

    // Backpressure: fill, third push ignored, then drain in order.
    drive(1'b1, 16'h0102, 1'b0);
    drive(1'b1, 16'h0304, 1'b0);
    drive(1'b1, 16'h0506, 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);

    // Simultaneous push/pop at count 1.
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b1);
    drive(1'b1, 16'h3333, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);

    // Parity vectors (data checked in every build, parity when enabled).
    drive(1'b1, 16'h0701, 1'b0);
    drive(1'b1, 16'h0300, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);

    // Reset asserted mid-cycle with two words buffered.
    drive(1'b1, 16'h4142, 1'b0);
    drive(1'b1, 16'h4344, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    a = 16'hBEEF;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_low_q",     {24'd0, low_q},     32'd0);
    check("mid_rst_high_q",    {24'd0, high_q},    32'd0);
    check("mid_rst_comb_low",  {24'd0, low},       32'h0000_00EF);
    check("mid_rst_comb_high", {24'd0, high},      32'h0000_00BE);
    sb.delete();
    exp_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After reset: buffered words are gone, new traffic works.
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b1, 16'h5A5A, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
